// File: rtl/seg_scan_capture.sv
// seg_scan_capture: samples a multiplexed seven-segment bus and rebuilds
// DIGITS hex nibbles per frame, delivered through a valid/ready handshake.
module seg_scan_capture #(
    parameter int DIGITS = 4,
    parameter int SETTLE = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DIGITS-1:0]     dig_sel,
    input  logic [6:0]            seg,
    output logic [4*DIGITS-1:0]   hex_out,
    output logic [DIGITS-1:0]     blank_out,
    output logic                  frame_valid,
    input  logic                  frame_ready,
    output logic                  pattern_err,
    output logic                  overrun
);
    localparam int W  = DIGITS + 7;
    localparam int CW = $clog2(SETTLE + 1);
    localparam int IW = DIGITS > 1 ? $clog2(DIGITS) : 1;
    localparam logic [CW-1:0] CMAX = CW'(SETTLE);
    localparam logic [CW-1:0] CSTB = CW'(SETTLE - 1);

    typedef enum logic {SETTLING, SAMPLED} state_t;
    state_t state, state_nx;

    logic [W-1:0]        sync0, s;
    logic [CW-1:0]       cnt;
    logic                chg, strobe, onehot, legal, blank, wr, bad, complete, load;
    logic [3:0]          nib;
    logic [IW-1:0]       idx;
    logic [4*DIGITS-1:0] stg_hex;
    logic [DIGITS-1:0]   stg_blank, seen;

    // chg looks one flop ahead so the counter restarts on the edge S changes
    assign chg      = sync0 != s;
    assign strobe   = state == SETTLING && !chg && cnt == CSTB;
    assign onehot   = $onehot(s[W-1:7]);
    assign wr       = strobe && onehot && legal;
    assign bad      = strobe && onehot && !legal;
    assign complete = &seen;
    assign load     = complete && (!frame_valid || frame_ready);

    always_comb begin
        legal = 1'b1;
        blank = 1'b0;
        nib   = 4'h0;
        case (s[6:0])
            7'h3F: nib = 4'h0;
            7'h06: nib = 4'h1;
            7'h5B: nib = 4'h2;
            7'h4F: nib = 4'h3;
            7'h66: nib = 4'h4;
            7'h6D: nib = 4'h5;
            7'h7D: nib = 4'h6;
            7'h07: nib = 4'h7;
            7'h7F: nib = 4'h8;
            7'h6F: nib = 4'h9;
            7'h77: nib = 4'hA;
            7'h7C: nib = 4'hB;
            7'h39: nib = 4'hC;
            7'h5E: nib = 4'hD;
            7'h79: nib = 4'hE;
            7'h71: nib = 4'hF;
            7'h00: blank = 1'b1;
            default: legal = 1'b0;
        endcase
    end

    always_comb begin
        idx = '0;
        for (int k = 0; k < DIGITS; k++)
            if (s[7+k]) idx = IW'(k);
    end

    always_comb begin
        state_nx = state;
        if (state == SETTLING && strobe) state_nx = SAMPLED;
        if (state == SAMPLED && chg)     state_nx = SETTLING;
    end

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) state <= SETTLING;
        else        state <= state_nx;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync0       <= '0;
            s           <= '0;
            cnt         <= '0;
            seen        <= '0;
            stg_hex     <= '0;
            stg_blank   <= '0;
            hex_out     <= '0;
            blank_out   <= '0;
            frame_valid <= 1'b0;
            pattern_err <= 1'b0;
            overrun     <= 1'b0;
        end else begin
            sync0       <= {dig_sel, seg};
            s           <= sync0;
            cnt         <= chg ? '0 : (cnt == CMAX ? cnt : cnt + 1'b1);
            pattern_err <= bad;
            overrun     <= complete && !load;
            if (complete)  seen <= '0;
            else if (wr)   seen[idx] <= 1'b1;
            else if (bad)  seen[idx] <= 1'b0;
            if (wr) begin
                stg_hex[{idx, 2'b00} +: 4] <= nib;
                stg_blank[idx]             <= blank;
            end
            if (load) begin
                hex_out   <= stg_hex;
                blank_out <= stg_blank;
            end
            frame_valid <= load || (frame_valid && !frame_ready);
        end
    end
endmodule

// File: tb/tb_seg_scan_capture.sv
// tb_seg_scan_capture: directed scans of the seven-segment bus with
// hand-computed frames, glitch, illegal glyph, overrun and reset cases.
module tb_seg_scan_capture;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  dig_sel = '0;
    logic [6:0]  seg = '0;
    logic [15:0] hex_out;
    logic [3:0]  blank_out;
    logic        frame_valid, frame_ready = 1'b1, pattern_err, overrun;

    int checks = 0, errors = 0;
    int pe_cnt = 0, ov_cnt = 0, hs_cnt = 0;
    logic [15:0] hs_hex = '0;
    logic [3:0]  hs_blank = '0;
    int pe0, ov0, hs0;

    seg_scan_capture #(.DIGITS(4), .SETTLE(4)) dut (
        .clk(clk), .rst_n(rst_n), .dig_sel(dig_sel), .seg(seg),
        .hex_out(hex_out), .blank_out(blank_out), .frame_valid(frame_valid),
        .frame_ready(frame_ready), .pattern_err(pattern_err), .overrun(overrun)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        pe_cnt += int'(pattern_err);
        ov_cnt += int'(overrun);
        if (frame_valid && frame_ready) begin
            hs_cnt++;
            hs_hex   = hex_out;
            hs_blank = blank_out;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic [3:0] sel, input logic [6:0] sg, input int n);
        dig_sel = sel;
        seg     = sg;
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic frame(input logic [6:0] g0, g1, g2, g3);
        step(4'b0001, g0, 10);
        step(4'b0010, g1, 10);
        step(4'b0100, g2, 10);
        step(4'b1000, g3, 10);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #2;
        chk("reset_hex", 32'(hex_out), 32'h0);
        chk("reset_valid", 32'(frame_valid), 32'h0);
        rst_n = 1'b1;

        frame(7'h3F, 7'h06, 7'h5B, 7'h4F);
        chk("f1_count", 32'(hs_cnt), 32'd1);
        chk("f1_hex", 32'(hs_hex), 32'h3210);
        chk("f1_blank", 32'(hs_blank), 32'h0);
        chk("f1_hold_hex", 32'(hex_out), 32'h3210);
        chk("f1_valid_drop", 32'(frame_valid), 32'h0);

        frame(7'h79, 7'h71, 7'h7C, 7'h00);
        chk("f2_count", 32'(hs_cnt), 32'd2);
        chk("f2_hex", 32'(hs_hex), 32'h0BFE);
        chk("f2_blank", 32'(hs_blank), 32'h8);

        step(4'b0001, 7'h3F, 10);
        step(4'b0001, 7'h7F, 3);
        step(4'b0010, 7'h06, 10);
        step(4'b0100, 7'h5B, 10);
        step(4'b1000, 7'h4F, 10);
        chk("glitch_hex", 32'(hs_hex), 32'h3210);
        chk("glitch_count", 32'(hs_cnt), 32'd3);

        pe0 = pe_cnt;
        step(4'b0001, 7'h3F, 10);
        step(4'b0010, 7'h01, 10);
        chk("perr_pulse", 32'(pe_cnt - pe0), 32'd1);
        step(4'b0100, 7'h5B, 10);
        step(4'b1000, 7'h4F, 10);
        step(4'b0011, 7'h3F, 10);
        chk("perr_no_frame", 32'(hs_cnt), 32'd3);
        step(4'b0010, 7'h06, 10);
        chk("perr_rescan_count", 32'(hs_cnt), 32'd4);
        chk("perr_rescan_hex", 32'(hs_hex), 32'h3210);
        chk("perr_total", 32'(pe_cnt - pe0), 32'd1);

        frame_ready = 1'b0;
        ov0 = ov_cnt;
        hs0 = hs_cnt;
        frame(7'h3F, 7'h06, 7'h5B, 7'h4F);
        chk("bp_valid1", 32'(frame_valid), 32'h1);
        frame(7'h66, 7'h6D, 7'h7D, 7'h07);
        chk("bp_valid2", 32'(frame_valid), 32'h1);
        chk("bp_hex_held", 32'(hex_out), 32'h3210);
        chk("bp_overrun", 32'(ov_cnt - ov0), 32'd1);
        step(4'b0001, 7'h77, 10);
        step(4'b0010, 7'h7C, 10);
        step(4'b0100, 7'h39, 10);
        step(4'b1000, 7'h5E, 6);
        chk("coinc_pre_hex", 32'(hex_out), 32'h3210);
        frame_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("coinc_valid", 32'(frame_valid), 32'h1);
        chk("coinc_hex", 32'(hex_out), 32'hDCBA);
        repeat (4) @(posedge clk);
        #2;
        chk("coinc_no_overrun", 32'(ov_cnt - ov0), 32'd1);
        chk("coinc_hs", 32'(hs_cnt - hs0), 32'd2);
        chk("coinc_hs_hex", 32'(hs_hex), 32'hDCBA);

        frame_ready = 1'b0;
        frame(7'h3F, 7'h06, 7'h5B, 7'h4F);
        step(4'b0001, 7'h79, 10);
        step(4'b0010, 7'h71, 10);
        chk("pre_rst_valid", 32'(frame_valid), 32'h1);
        hs0 = hs_cnt;
        rst_n = 1'b0;
        dig_sel = '0;
        seg = '0;
        #1;
        chk("rst_hex", 32'(hex_out), 32'h0);
        chk("rst_blank", 32'(blank_out), 32'h0);
        chk("rst_valid", 32'(frame_valid), 32'h0);
        chk("rst_pulses", 32'({pattern_err, overrun}), 32'h0);
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b1;
        frame_ready = 1'b1;
        step(4'b0100, 7'h7C, 10);
        step(4'b1000, 7'h00, 10);
        chk("post_rst_partial", 32'(hs_cnt - hs0), 32'd0);
        step(4'b0001, 7'h79, 10);
        step(4'b0010, 7'h71, 10);
        chk("post_rst_count", 32'(hs_cnt - hs0), 32'd1);
        chk("post_rst_hex", 32'(hs_hex), 32'h0BFE);
        chk("post_rst_blank", 32'(hs_blank), 32'h8);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
